// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl
//   Shares one iterative signed shift-add multiplier between two requesters.
//   Arbitration is round-robin. The engine converts both operands to magnitudes,
//   runs WIDTH add/shift steps, then restores the sign. Only one operation is in
//   flight at a time.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req0_valid/ready/a/b       requester 0 operand handshake (signed operands)
//   req1_valid/ready/a/b       requester 1 operand handshake (signed operands)
//   rsp_valid/ready            product handshake
//   rsp_id                     requester that owns rsp_product
//   rsp_product                signed 2*WIDTH-bit product
//   busy                       high whenever the engine is not idle
module mul_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic                 busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_SIGN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]         rsp_product_q, rsp_product_d;

  logic signed [WIDTH-1:0]    a_q, a_d;
  logic signed [WIDTH-1:0]    b_q, b_d;
  logic                       id_q, id_d;
  logic [WIDTH-1:0]           mag_a_q, mag_a_d;
  logic                       neg_q, neg_d;
  logic [2*WIDTH-1:0]         acc_q, acc_d;
  logic [WIDTH:0]             sum_w;

  logic                       grant0, grant1;
  logic                       acc0, acc1;

  // Magnitude as an unsigned value; the most negative input maps to 2**(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = $unsigned(v);
    return v[WIDTH-1] ? (~u + {{(WIDTH-1){1'b0}}, 1'b1}) : u;
  endfunction

  // Round-robin: with both valid, favour the requester not served last.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant_q);
    grant1 = req1_valid && (!req0_valid || !last_grant_q);
  end

  // Output decode
  always_comb begin
    req0_ready = (state_q == S_IDLE) && grant0;
    req1_ready = (state_q == S_IDLE) && grant1;
    busy       = (state_q != S_IDLE);
    acc0       = req0_valid && req0_ready;
    acc1       = req1_valid && req1_ready;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (acc0 || acc1) state_d = S_LOAD;
      S_LOAD: state_d = S_RUN;
      S_RUN:  if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_SIGN;
      S_SIGN: state_d = S_DONE;
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and response next values
  always_comb begin
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    mag_a_d       = mag_a_q;
    neg_d         = neg_q;
    acc_d         = acc_q;
    sum_w         = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
    case (state_q)
      S_IDLE: begin
        if (acc0) begin
          a_d = req0_a; b_d = req0_b; id_d = 1'b0; last_grant_d = 1'b0;
        end else if (acc1) begin
          a_d = req1_a; b_d = req1_b; id_d = 1'b1; last_grant_d = 1'b1;
        end
      end
      S_LOAD: begin
        mag_a_d = mag_of(a_q);
        acc_d   = {{WIDTH{1'b0}}, mag_of(b_q)};
        neg_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        cnt_d   = '0;
      end
      S_RUN: begin
        // Upper half accumulates, lower half shifts the multiplier bits out.
        acc_d = acc_q[0] ? {sum_w, acc_q[WIDTH-1:1]} : (acc_q >> 1);
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_SIGN: begin
        rsp_product_d = neg_q ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
        rsp_id_d      = id_q;
        rsp_valid_d   = 1'b1;
      end
      S_DONE: if (rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  // State register and control flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_product_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  // Operand and accumulator flops; only meaningful while an operation runs
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    id_q    <= id_d;
    mag_a_q <= mag_a_d;
    neg_q   <= neg_d;
    acc_q   <= acc_d;
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;

endmodule
